md_hilo_unit: RTL and testbench

- Iterative multiply/divide unit with the architectural HI/LO registers, in the EX stage beside the main ALU.
- Executes MULT/MULTU/DIV/DIVU/MTHI/MTLO and supplies HI/LO to MFHI/MFLO, which feed the decode-stage forwarding muxes as the hi_low source.
- Drives `busy` so the hazard unit can stall the front end while an operation is in flight.

---
 rtl/md_pkg.sv | 46 ++++
 rtl/md_div_step.sv | 26 ++
 rtl/md_hilo_unit.sv | 168 ++++++++++++++++
 tb/tb_md_hilo_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared encodings and op classification for the multiply/divide HI/LO unit.
// Optional MADD/MADDU/MSUB/MSUBU support is enabled by defining MD_HILO_MACC_EN.
package md_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8,
        OP_MSUB  = 4'd9,
        OP_MSUBU = 4'd10
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DIVFIX
    } md_state_e;

    localparam int unsigned CNT_W = 5;

    function automatic logic isMul(input logic [3:0] op);
        case (op)
            OP_MULT, OP_MULTU: return 1'b1;
`ifdef MD_HILO_MACC_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic isDiv(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic isSignedOp(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

endpackage

// File: rtl/md_div_step.sv
// One restoring-division iteration: shift {rem,quo} left, subtract divisor when it fits.
module md_div_step (
    input  logic [31:0] remIn,
    input  logic [31:0] quoIn,
    input  logic [31:0] divisor,
    output logic [31:0] remOut,
    output logic [31:0] quoOut
);

    logic [32:0] remShift;
    logic [31:0] diff;

    always_comb begin
        remShift = {remIn, quoIn[31]};
        // Remainder after subtraction is always below the divisor, so 32 bits suffice.
        diff     = remShift[31:0] - divisor;
        if (remShift >= {1'b0, divisor}) begin
            remOut = diff;
            quoOut = {quoIn[30:0], 1'b1};
        end else begin
            remOut = remShift[31:0];
            quoOut = {quoIn[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/md_hilo_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Define MD_HILO_MACC_EN to add MADD/MADDU/MSUB/MSUBU accumulate ops on the MUL path.
module md_hilo_unit
    import md_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned DIV_ITERS  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        md_start,
    input  logic [3:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e        state, nextState;
    logic [CNT_W-1:0] cnt;
    logic [63:0]      mulA, mulB, product, mulResult;
    logic [31:0]      rem, quo, divisor, remNext, quoNext, remFix, quoFix;
    logic             negQuo, negRem, divZero;
    logic [31:0]      hiReg, loReg;
    logic             doneReg;
    logic             startOk, startMul, startDiv, opSigned;
`ifdef MD_HILO_MACC_EN
    logic             accAdd, accSub;
`endif

    assign startOk  = md_start & ~flush;
    assign startMul = startOk & isMul(md_op);
    assign startDiv = startOk & isDiv(md_op);
    assign opSigned = isSignedOp(md_op);

    assign product = mulA * mulB;
`ifdef MD_HILO_MACC_EN
    always_comb begin
        mulResult = product;
        if (accAdd)
            mulResult = {hiReg, loReg} + product;
        else if (accSub)
            mulResult = {hiReg, loReg} - product;
    end
`else
    assign mulResult = product;
`endif

    md_div_step divStep (
        .remIn  (rem),
        .quoIn  (quo),
        .divisor(divisor),
        .remOut (remNext),
        .quoOut (quoNext)
    );

    // Divide-by-zero yields an all-ones quotient regardless of operand signs.
    assign quoFix = divZero ? '1 : (negQuo ? -quo : quo);
    assign remFix = negRem ? -rem : rem;

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        busy      = (state != ST_IDLE) | startMul | startDiv;
        case (state)
            ST_IDLE: begin
                if (startMul)
                    nextState = ST_MUL;
                else if (startDiv)
                    nextState = ST_DIV;
            end
            ST_MUL:    if (cnt == '0) nextState = ST_IDLE;
            ST_DIV:    if (cnt == '0) nextState = ST_DIVFIX;
            ST_DIVFIX: nextState = ST_IDLE;
            default:   nextState = ST_IDLE;
        endcase
        if (flush && state != ST_IDLE)
            nextState = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            mulA    <= '0;
            mulB    <= '0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            negQuo  <= 1'b0;
            negRem  <= 1'b0;
            divZero <= 1'b0;
            hiReg   <= '0;
            loReg   <= '0;
            doneReg <= 1'b0;
`ifdef MD_HILO_MACC_EN
            accAdd  <= 1'b0;
            accSub  <= 1'b0;
`endif
        end else begin
            doneReg <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (startMul) begin
                        mulA <= opSigned ? {{32{a[31]}}, a} : {32'b0, a};
                        mulB <= opSigned ? {{32{b[31]}}, b} : {32'b0, b};
                        cnt  <= CNT_W'(MUL_CYCLES - 1);
`ifdef MD_HILO_MACC_EN
                        accAdd <= (md_op == OP_MADD) || (md_op == OP_MADDU);
                        accSub <= (md_op == OP_MSUB) || (md_op == OP_MSUBU);
`endif
                    end else if (startDiv) begin
                        rem     <= '0;
                        quo     <= (opSigned && a[31]) ? -a : a;
                        divisor <= (opSigned && b[31]) ? -b : b;
                        negQuo  <= opSigned && (a[31] ^ b[31]);
                        negRem  <= opSigned && a[31];
                        divZero <= (b == '0);
                        cnt     <= CNT_W'(DIV_ITERS - 1);
                    end else if (startOk && md_op == OP_MTHI) begin
                        hiReg <= a;
                    end else if (startOk && md_op == OP_MTLO) begin
                        loReg <= a;
                    end
                end
                ST_MUL: begin
                    if (!flush) begin
                        if (cnt == '0) begin
                            {hiReg, loReg} <= mulResult;
                            doneReg        <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                ST_DIV: begin
                    if (!flush) begin
                        rem <= remNext;
                        quo <= quoNext;
                        if (cnt != '0)
                            cnt <= cnt - 1'b1;
                    end
                end
                ST_DIVFIX: begin
                    if (!flush) begin
                        hiReg   <= remFix;
                        loReg   <= quoFix;
                        doneReg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi   = hiReg;
    assign lo   = loReg;
    assign done = doneReg;

endmodule

// File: tb/tb_md_hilo_unit.sv
// Self-checking bench for md_hilo_unit: table-driven mul/div vectors with a result
// scoreboard, plus hand sequences for MTHI/MTLO, flush, reset and MD_HILO_MACC_EN ops.
module tb_md_hilo_unit;
    import md_pkg::*;

    localparam int unsigned MULC = 2;
    localparam int unsigned DIVL = 33;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
        int unsigned lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        md_start;
    logic [3:0]  md_op;
    logic [31:0] a, b;
    logic        flush;
    logic        busy, done;
    logic [31:0] hi, lo;

    int unsigned vecCount  = 0;
    int unsigned missCount = 0;
    logic [63:0] expQ[$];
    logic [31:0] modelHi, modelLo;
    vec_t        vecs[14];

    md_hilo_unit #(.MUL_CYCLES(MULC), .DIV_ITERS(32)) dut (
        .clk(clk), .rst(rst), .md_start(md_start), .md_op(md_op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic runVec(input vec_t v);
        int unsigned n;
        logic [63:0] exp;
        assert (busy == 1'b0) else $error("FAIL md_start issued while unit busy");
        md_start = 1'b1; md_op = v.op; a = v.a; b = v.b;
        #1 check("busyStart", busy, 1'b1);
        expQ.push_back({v.expHi, v.expLo});
        @(negedge clk);
        md_start = 1'b0; md_op = OP_NONE; a = $urandom; b = $urandom;
        n = 0;
        while (!done && n < 100) begin
            check("busyRun", busy, 1'b1);
            @(negedge clk);
            n++;
        end
        if (!done) begin
            check("doneTimeout", 32'(done), 32'd1);
            void'(expQ.pop_front());
        end else begin
            exp = expQ.pop_front();
            check("latency", n, v.lat);
            check("hi", hi, exp[63:32]);
            check("lo", lo, exp[31:0]);
            check("busyDone", busy, 1'b0);
            modelHi = exp[63:32];
            modelLo = exp[31:0];
            @(negedge clk);
            check("donePulse", done, 1'b0);
        end
    endtask

    task automatic mtOp(input logic [3:0] op, input logic [31:0] val, input logic fl);
        md_start = 1'b1; md_op = op; a = val; flush = fl;
        #1 check("mtBusy", busy, 1'b0);
        @(negedge clk);
        md_start = 1'b0; md_op = OP_NONE; flush = 1'b0;
        if (!fl && op == OP_MTHI) modelHi = val;
        if (!fl && op == OP_MTLO) modelLo = val;
        check("mtHi", hi, modelHi);
        check("mtLo", lo, modelLo);
        check("mtDone", done, 1'b0);
    endtask

    task automatic quietCycles(input int unsigned cycles);
        int unsigned pulses = 0;
        for (int unsigned i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("noDone", pulses, 0);
        check("quietHi", hi, modelHi);
        check("quietLo", lo, modelLo);
    endtask

    initial begin
        vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, MULC};
        vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MULC};
        vecs[2]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MULC};
        vecs[3]  = '{OP_MULTU, 32'h12345678, 32'd9,        32'h00000000, 32'hA3D70A38, MULC};
        vecs[4]  = '{OP_MULT,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, MULC};
        vecs[5]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       DIVL};
        vecs[6]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DIVL};
        vecs[7]  = '{OP_DIV,   32'h80000000, 32'd0,        32'h80000000, 32'hFFFFFFFF, DIVL};
        vecs[8]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIVL};
        vecs[9]  = '{OP_DIVU,  32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF, DIVL};
        vecs[10] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, DIVL};
        vecs[11] = '{OP_DIVU,  32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF, DIVL};
        vecs[12] = '{OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, DIVL};
        vecs[13] = '{OP_DIVU,  32'd5,        32'd9,        32'd5,        32'd0,        DIVL};

        rst = 1'b1; md_start = 1'b0; md_op = OP_NONE; a = '0; b = '0; flush = 1'b0;
        modelHi = '0; modelLo = '0;
        repeat (3) @(negedge clk);
        check("rstHi", hi, 32'd0);
        check("rstLo", lo, 32'd0);
        check("rstBusy", busy, 1'b0);
        check("rstDone", done, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        for (int unsigned i = 0; i < 14; i++)
            runVec(vecs[i]);

        // MTHI/MTLO write at the start edge; flush suppresses them.
        mtOp(OP_MTHI, 32'h12345678, 1'b0);
        mtOp(OP_MTLO, 32'h0BADF00D, 1'b0);
        mtOp(OP_MTHI, 32'hDEADBEEF, 1'b1);
        quietCycles(3);

        // Flush part-way through a DIVU leaves HI/LO untouched.
        mtOp(OP_MTHI, 32'hAAAA5555, 1'b0);
        mtOp(OP_MTLO, 32'hAAAA5555, 1'b0);
        md_start = 1'b1; md_op = OP_DIVU; a = 32'd100; b = 32'd7;
        @(negedge clk);
        md_start = 1'b0; md_op = OP_NONE;
        repeat (10) @(negedge clk);
        check("busyBeforeFlush", busy, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flushBusy", busy, 1'b0);
        check("flushDone", done, 1'b0);
        quietCycles(40);

        // Reset mid-MUL clears HI/LO.
        md_start = 1'b1; md_op = OP_MULT; a = 32'd3; b = 32'd5;
        @(negedge clk);
        md_start = 1'b0; md_op = OP_NONE; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        modelHi = '0; modelLo = '0;
        check("midRstBusy", busy, 1'b0);
        check("midRstHi", hi, 32'd0);
        check("midRstLo", lo, 32'd0);
        quietCycles(4);

        runVec(vecs[0]);

        mtOp(OP_MTHI, 32'h0, 1'b0);
        mtOp(OP_MTLO, 32'hFFFFFFFF, 1'b0);
`ifdef MD_HILO_MACC_EN
        runVec('{OP_MADDU, 32'd1, 32'd1, 32'd1, 32'd0, MULC});
        runVec('{OP_MSUB,  32'd2, 32'd3, 32'd0, 32'hFFFFFFFA, MULC});
`else
        md_start = 1'b1; md_op = OP_MADDU; a = 32'd1; b = 32'd1;
        #1 check("maccBusy", busy, 1'b0);
        @(negedge clk);
        md_start = 1'b0; md_op = OP_NONE;
        check("maccBusyAfter", busy, 1'b0);
        quietCycles(4);
`endif

        check("scoreboardEmpty", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
